falu16_dispatch: RTL and testbench
==================================

// Module: falu16_dispatch
// PURPOSE
//  Operand/opcode issue stage that sits directly upstream of FALU16 and consumes its result.
//  Buffers half-precision requests from the scalar/vector front end in a small FIFO.
//  Drives FALU16 op1/op2, enable and one-hot op-select lines, then captures opout after a fixed latency.
//  Returns each result with the requester's tag over a valid/ready channel.
// PARAMETERS
//  DEPTH   4  request FIFO entries (power of 2, >=2)
//  TAG_W   4  request tag width
//  ALU_LAT 1  cycles from FALU16 input change to valid opout (0 = combinational, treated as 1)
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  flush      in   1      sync abort: drop FIFO, in-flight op and pending response
//  req_valid  in   1      request valid
//  req_ready  out  1      FIFO not full
//  req_op     in   3      0 add,1 sub,2 mul,3 max,4 min,5 itf,6 fti,7 reserved
//  req_a      in   16     operand A (half float / int16 for itf)
//  req_b      in   16     operand B
//  req_tag    in   TAG_W  requester tag
//  alu_enable out  1      FALU16 enable
//  alu_op1    out  16     FALU16 op1
//  alu_op2    out  16     FALU16 op2
//  alu_sel    out  7      one-hot {ftisel,itfsel,minsel,maxsel,mulsel,subsel,addsel}
//  alu_result in   16     FALU16 opout
//  rsp_valid  out  1      response valid
//  rsp_ready  in   1      response accepted
//  rsp_data   out  16     captured opout
//  rsp_tag    out  TAG_W  tag of the response
// BEHAVIOUR
//  Reset (rst_n low, async): FIFO empty, state IDLE, alu_enable=0, alu_sel=0, alu_op1/op2=0, rsp_valid=0, rsp_data=0, rsp_tag=0.
//  req_ready=!full; it is 0 while rst_n is low. Push when req_valid&&req_ready.
//  FSM IDLE -> ISSUE: FIFO non-empty; pop the head into operand/op/tag registers.
//  ISSUE: alu_enable=1, alu_sel=onehot(op), operands held stable; a counter runs max(ALU_LAT,1) cycles.
//  ISSUE, last cycle: rsp_data<=alu_result; rsp_tag<=tag; -> RESP.
//  RESP: rsp_valid=1, rsp_data/rsp_tag held until rsp_ready.
//    On accept: if FIFO is non-empty, pop and go -> ISSUE (back-to-back); otherwise -> IDLE.
//  alu_sel=0 and alu_enable=0 in IDLE and RESP. Operand registers keep their last value.
//  Latency with FIFO empty and ALU_LAT=1: accept at edge N, ISSUE during N+1, rsp_valid at N+2.
//  Throughput: one op per max(ALU_LAT,1)+1 cycles when rsp_ready is held high.
//  Ordering: responses in strict request order.
//  Simultaneous push and pop: allowed. Full+pop: req_ready reflects full only, with no same-cycle pass-through.
//  Pointers wrap mod DEPTH. Count is DEPTH+1 states wide (log2(DEPTH)+1 bits).
//  Opcode 7: treated as add unless FALU16_DISP_ILLEGAL_EN is defined.
//  flush: next edge -> IDLE, FIFO empty, rsp_valid=0, alu_sel=0. flush beats a simultaneous push (the push is dropped).
//  Reset mid-op: in-flight op and FIFO contents are lost; no response is emitted.
// CONFIGURATION
//  FALU16_DISP_ILLEGAL_EN defined:
//    Adds output rsp_err (1b, reset 0).
//    Opcode 7 is still popped but never issued: alu_enable stays 0, and it goes IDLE -> RESP directly.
//    The response has rsp_data=16'h7E00 (qNaN) and rsp_err=1. Ordering is preserved.
//  FALU16_DISP_ILLEGAL_EN undefined: no rsp_err port; opcode 7 is issued as add.
// STRUCTURE
//  falu16_pkg: opcode localparams (FOP_ADD..FOP_FTI, FOP_RSV), alu_sel bit indices, FSM state encodings (IDLE/ISSUE/RESP).
//  Sub-module falu16_disp_fifo: synchronous DEPTH x (3+16+16+TAG_W) FIFO.
//    Ports: push/pop, full/empty, sync clear, async active-low reset.
//  Top level holds the FSM, latency counter, operand registers and response registers.
// TESTING
//  1 add 3C00+4000, tag 1, ALU_LAT=1 -> addsel pulse 1 cycle; rsp_valid at N+2, rsp_data=4200, rsp_tag=1.
//  2 Back-to-back mul 4000*4200 (tag 2) then sub 4200-3C00 (tag 3), rsp_ready=1.
//    -> rsp 4600/2, then 4000/3, 2 cycles apart, in order.
//  3 Push 5 requests with rsp_ready=0 -> req_ready=0 after 4 are buffered plus 1 in RESP.
//    rsp_data stays stable; after release, all 5 return in order.
//  4 flush during ISSUE with 3 queued -> next cycle alu_sel=0, FIFO empty, no rsp_valid.
//    A new request afterwards completes normally.
//  5 rst_n low mid-ISSUE -> all outputs 0 immediately (async); after release req_ready=1.
//  6 (ILLEGAL_EN) op=7, tag 5 -> alu_enable never 1; rsp_data=7E00, rsp_err=1, rsp_tag=5.

Source files
------------

// File: rtl/falu16_pkg.sv
// falu16_pkg: opcodes, alu_sel bit positions and dispatch FSM states shared by the FALU16 dispatch slice
package falu16_pkg;
  localparam logic [2:0] FOP_ADD = 3'd0;
  localparam logic [2:0] FOP_SUB = 3'd1;
  localparam logic [2:0] FOP_MUL = 3'd2;
  localparam logic [2:0] FOP_MAX = 3'd3;
  localparam logic [2:0] FOP_MIN = 3'd4;
  localparam logic [2:0] FOP_ITF = 3'd5;
  localparam logic [2:0] FOP_FTI = 3'd6;
  localparam logic [2:0] FOP_RSV = 3'd7;
  localparam int SEL_ADD = 0;
  localparam int SEL_SUB = 1;
  localparam int SEL_MUL = 2;
  localparam int SEL_MAX = 3;
  localparam int SEL_MIN = 4;
  localparam int SEL_ITF = 5;
  localparam int SEL_FTI = 6;
  localparam logic [15:0] QNAN16 = 16'h7E00;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESP} state_t;
  // Opcode n drives select bit n; the reserved opcode falls back to add
  function automatic logic [6:0] op_onehot(input logic [2:0] op);
    return op == FOP_RSV ? 7'(1 << SEL_ADD) : 7'd1 << op;
  endfunction
endpackage

// File: rtl/falu16_disp_fifo.sv
// falu16_disp_fifo: DEPTH x W synchronous request FIFO with sync clear and async active-low reset
module falu16_disp_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 39
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rp];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push && !clr) mem[wp] <= din;
endmodule

// File: rtl/falu16_dispatch.sv
// falu16_dispatch: FIFO-buffered operand/opcode issue stage for FALU16 with tagged valid/ready responses.
// Defining FALU16_DISP_ILLEGAL_EN adds rsp_err and answers opcode 7 with qNaN instead of issuing it.
module falu16_dispatch
  import falu16_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [15:0]      req_a,
  input  logic [15:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             alu_enable,
  output logic [15:0]      alu_op1,
  output logic [15:0]      alu_op2,
  output logic [6:0]       alu_sel,
  input  logic [15:0]      alu_result,
`ifdef FALU16_DISP_ILLEGAL_EN
  output logic             rsp_err,
`endif
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag
);
  localparam int LAT = ALU_LAT < 1 ? 1 : ALU_LAT;
  localparam int CW = LAT > 1 ? $clog2(LAT) : 1;
  localparam int FW = 35 + TAG_W;
  state_t state, nstate;
  logic [FW-1:0] f_dout;
  logic full, empty, push, pop, start, last, h_ill;
  logic [2:0] h_op, op_r;
  logic [15:0] h_a, h_b;
  logic [TAG_W-1:0] h_tag, tag_r;
  logic [CW-1:0] cnt;
  assign req_ready = rst_n && !full;
  assign push = req_valid && req_ready && !flush;
  assign {h_op, h_a, h_b, h_tag} = f_dout;
  assign start = !empty && (state == ST_IDLE || (state == ST_RESP && rsp_ready));
  assign pop = start && !flush;
  assign last = cnt == CW'(LAT - 1);
  assign alu_enable = state == ST_ISSUE;
  assign alu_sel = alu_enable ? op_onehot(op_r) : 7'd0;
  assign rsp_valid = state == ST_RESP;
`ifdef FALU16_DISP_ILLEGAL_EN
  assign h_ill = h_op == FOP_RSV;
`else
  assign h_ill = 1'b0;
`endif
  falu16_disp_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .clr(flush),
    .push(push),
    .pop(pop),
    .din({req_op, req_a, req_b, req_tag}),
    .dout(f_dout),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE: nstate = start ? (h_ill ? ST_RESP : ST_ISSUE) : ST_IDLE;
      ST_ISSUE: nstate = last ? ST_RESP : ST_ISSUE;
      ST_RESP: nstate = rsp_ready ? (start ? (h_ill ? ST_RESP : ST_ISSUE) : ST_IDLE) : ST_RESP;
      default: nstate = ST_IDLE;
    endcase
    if (flush) nstate = ST_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      op_r <= '0;
      alu_op1 <= '0;
      alu_op2 <= '0;
      tag_r <= '0;
      cnt <= '0;
      rsp_data <= '0;
      rsp_tag <= '0;
    end else begin
      state <= nstate;
      if (pop) begin
        op_r <= h_op;
        alu_op1 <= h_a;
        alu_op2 <= h_b;
        tag_r <= h_tag;
        cnt <= '0;
      end else if (state == ST_ISSUE) cnt <= cnt + 1'b1;
      if (state == ST_ISSUE && last) begin
        rsp_data <= alu_result;
        rsp_tag <= tag_r;
      end
      // Illegal opcodes skip ISSUE, so their response is formed at pop time
      if (pop && h_ill) begin
        rsp_data <= QNAN16;
        rsp_tag <= h_tag;
      end
    end
  end
`ifdef FALU16_DISP_ILLEGAL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_err <= 1'b0;
    else if (pop && h_ill) rsp_err <= 1'b1;
    else if (state == ST_ISSUE && last) rsp_err <= 1'b0;
  end
`endif
endmodule

// File: tb/tb_falu16_dispatch.sv
// tb_falu16_dispatch: directed self-checking bench for falu16_dispatch against a combinational FALU16 stub.
// Define FALU16_DISP_ILLEGAL_EN for both bench and RTL to exercise the illegal-opcode response.
module tb_falu16_dispatch;
  localparam int TAG_W = 4;
  logic clk = 1'b0, rst_n, flush, req_valid, req_ready, alu_enable, rsp_valid, rsp_ready;
  logic [2:0] req_op;
  logic [15:0] req_a, req_b, alu_op1, alu_op2, alu_result, rsp_data;
  logic [6:0] alu_sel;
  logic [TAG_W-1:0] req_tag, rsp_tag;
`ifdef FALU16_DISP_ILLEGAL_EN
  logic rsp_err;
`endif
  int compared = 0, mism = 0;
  always #5 clk = ~clk;
  falu16_dispatch #(.DEPTH(4), .TAG_W(TAG_W), .ALU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_enable(alu_enable), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_sel(alu_sel), .alu_result(alu_result),
`ifdef FALU16_DISP_ILLEGAL_EN
    .rsp_err(rsp_err),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag)
  );
  // FALU16 stub: exact half-float answers for the directed vectors, simple integer stand-ins otherwise
  always_comb begin
    case (alu_sel)
      7'h01: alu_result = (alu_op1 == 16'h3C00 && alu_op2 == 16'h4000) ? 16'h4200 : alu_op1 + alu_op2;
      7'h02: alu_result = (alu_op1 == 16'h4200 && alu_op2 == 16'h3C00) ? 16'h4000 : alu_op1 - alu_op2;
      7'h04: alu_result = (alu_op1 == 16'h4000 && alu_op2 == 16'h4200) ? 16'h4600 : alu_op1 ^ alu_op2;
      7'h08: alu_result = alu_op1 > alu_op2 ? alu_op1 : alu_op2;
      default: alu_result = 16'hDEAD;
    endcase
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string t, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s observed=%h expected=%h", t, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag);
    req_valid = v;
    req_op = op;
    req_a = a;
    req_b = b;
    req_tag = tag;
  endtask
  task automatic wait_valid(input string t);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk(t, 16'(rsp_valid), 16'd1);
  endtask
  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    rsp_ready = 1'b0;
    drive(1'b0, 3'd0, 16'h0, 16'h0, 4'd0);
    step();
    step();
    chk("rst_req_ready", 16'(req_ready), 16'd0);
    chk("rst_enable", 16'(alu_enable), 16'd0);
    chk("rst_sel", 16'(alu_sel), 16'd0);
    chk("rst_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("rst_rsp_data", rsp_data, 16'h0000);
    #4 rst_n = 1'b1;
    step();
    chk("post_rst_ready", 16'(req_ready), 16'd1);
    // single add, latency check
    rsp_ready = 1'b1;
    drive(1'b1, 3'd0, 16'h3C00, 16'h4000, 4'd1);
    step();
    req_valid = 1'b0;
    chk("t1_idle_enable", 16'(alu_enable), 16'd0);
    step();
    chk("t1_issue_enable", 16'(alu_enable), 16'd1);
    chk("t1_issue_sel", 16'(alu_sel), 16'h0001);
    chk("t1_issue_op1", alu_op1, 16'h3C00);
    step();
    chk("t1_rsp_valid", 16'(rsp_valid), 16'd1);
    chk("t1_rsp_data", rsp_data, 16'h4200);
    chk("t1_rsp_tag", 16'(rsp_tag), 16'd1);
    chk("t1_resp_sel", 16'(alu_sel), 16'd0);
    step();
    chk("t1_rsp_done", 16'(rsp_valid), 16'd0);
    // back-to-back mul then sub
    drive(1'b1, 3'd2, 16'h4000, 16'h4200, 4'd2);
    step();
    drive(1'b1, 3'd1, 16'h4200, 16'h3C00, 4'd3);
    step();
    req_valid = 1'b0;
    chk("t2_mul_sel", 16'(alu_sel), 16'h0004);
    step();
    chk("t2_rsp0_valid", 16'(rsp_valid), 16'd1);
    chk("t2_rsp0_data", rsp_data, 16'h4600);
    chk("t2_rsp0_tag", 16'(rsp_tag), 16'd2);
    step();
    chk("t2_gap_valid", 16'(rsp_valid), 16'd0);
    chk("t2_sub_sel", 16'(alu_sel), 16'h0002);
    step();
    chk("t2_rsp1_valid", 16'(rsp_valid), 16'd1);
    chk("t2_rsp1_data", rsp_data, 16'h4000);
    chk("t2_rsp1_tag", 16'(rsp_tag), 16'd3);
    step();
    chk("t2_done", 16'(rsp_valid), 16'd0);
    // backpressure: 1 held in RESP + 4 buffered
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_ready_%0d", i), 16'(req_ready), 16'd1);
      drive(1'b1, 3'd0, 16'h0001 + 16'(i), 16'h0100, 4'(4 + i));
      step();
    end
    req_valid = 1'b0;
    chk("t3_full", 16'(req_ready), 16'd0);
    chk("t3_hold_data", rsp_data, 16'h0101);
    step();
    step();
    step();
    chk("t3_stable_valid", 16'(rsp_valid), 16'd1);
    chk("t3_stable_data", rsp_data, 16'h0101);
    chk("t3_stable_tag", 16'(rsp_tag), 16'd4);
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_valid($sformatf("t3_valid_%0d", k));
      chk($sformatf("t3_data_%0d", k), rsp_data, 16'h0101 + 16'(k));
      chk($sformatf("t3_tag_%0d", k), 16'(rsp_tag), 16'(4 + k));
      step();
    end
    step();
    chk("t3_drained", 16'(rsp_valid), 16'd0);
    // flush during ISSUE with 3 queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'd0, 16'h0010 + 16'(i), 16'h0200, 4'(i));
      step();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("t4_issue_enable", 16'(alu_enable), 16'd1);
    chk("t4_issue_op1", alu_op1, 16'h0011);
    flush = 1'b1;
    drive(1'b1, 3'd1, 16'h1111, 16'h2222, 4'd15);
    step();
    flush = 1'b0;
    req_valid = 1'b0;
    chk("t4_flush_sel", 16'(alu_sel), 16'd0);
    chk("t4_flush_enable", 16'(alu_enable), 16'd0);
    chk("t4_flush_valid", 16'(rsp_valid), 16'd0);
    step();
    step();
    step();
    chk("t4_quiet_valid", 16'(rsp_valid), 16'd0);
    chk("t4_quiet_enable", 16'(alu_enable), 16'd0);
    chk("t4_empty_ready", 16'(req_ready), 16'd1);
    rsp_ready = 1'b1;
    drive(1'b1, 3'd3, 16'h4400, 16'h4200, 4'd9);
    step();
    req_valid = 1'b0;
    step();
    chk("t4_max_sel", 16'(alu_sel), 16'h0008);
    wait_valid("t4_new_valid");
    chk("t4_new_data", rsp_data, 16'h4400);
    chk("t4_new_tag", 16'(rsp_tag), 16'd9);
    step();
    // async reset mid-ISSUE
    drive(1'b1, 3'd0, 16'h3C00, 16'h4000, 4'd7);
    step();
    req_valid = 1'b0;
    step();
    chk("t5_issue_enable", 16'(alu_enable), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_enable", 16'(alu_enable), 16'd0);
    chk("t5_async_sel", 16'(alu_sel), 16'd0);
    chk("t5_async_op1", alu_op1, 16'h0000);
    chk("t5_async_op2", alu_op2, 16'h0000);
    chk("t5_async_valid", 16'(rsp_valid), 16'd0);
    chk("t5_async_data", rsp_data, 16'h0000);
    chk("t5_async_tag", 16'(rsp_tag), 16'd0);
    chk("t5_async_ready", 16'(req_ready), 16'd0);
    step();
    #4 rst_n = 1'b1;
    step();
    chk("t5_release_ready", 16'(req_ready), 16'd1);
    step();
    step();
    chk("t5_no_rsp", 16'(rsp_valid), 16'd0);
    chk("t5_no_issue", 16'(alu_enable), 16'd0);
    // opcode 7
`ifdef FALU16_DISP_ILLEGAL_EN
    drive(1'b1, 3'd7, 16'h0005, 16'h0003, 4'd5);
    step();
    req_valid = 1'b0;
    chk("t6_enable_a", 16'(alu_enable), 16'd0);
    step();
    chk("t6_enable_b", 16'(alu_enable), 16'd0);
    chk("t6_valid", 16'(rsp_valid), 16'd1);
    chk("t6_data", rsp_data, 16'h7E00);
    chk("t6_err", 16'(rsp_err), 16'd1);
    chk("t6_tag", 16'(rsp_tag), 16'd5);
    step();
    chk("t6_done", 16'(rsp_valid), 16'd0);
`else
    drive(1'b1, 3'd7, 16'h0005, 16'h0003, 4'd6);
    step();
    req_valid = 1'b0;
    step();
    chk("t6_rsv_sel", 16'(alu_sel), 16'h0001);
    step();
    chk("t6_rsv_valid", 16'(rsp_valid), 16'd1);
    chk("t6_rsv_data", rsp_data, 16'h0008);
    chk("t6_rsv_tag", 16'(rsp_tag), 16'd6);
    step();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
